// File: rtl/irq_sequencer.sv
// irq_sequencer: four-source interrupt controller driving the EPC register of the
// single-cycle MIPS core. Captures rising edges of IRQ into PENDING, masks them,
// grants one at an instruction boundary, pulses EPC_WE, waits for ERET, then
// pulses EPC_RE.
// Build option: define IRQ_ROUND_ROBIN_EN for rotating priority; otherwise the
// priority is fixed with source 0 highest.
module irq_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] IRQ,
  input  logic       ACCEPT,
  input  logic       ERET,
  input  logic       MASK_WE,
  input  logic [3:0] MASK_D,
  output logic [3:0] MASK_Q,
  output logic [3:0] PENDING,
  output logic       EPC_WE,
  output logic       EPC_RE,
  output logic [1:0] EPC_ID,
  output logic       BUSY
);

  typedef enum logic [1:0] {StIdle, StVector, StService, StRestore} state_e;

  state_e     state_q, state_d;
  logic [3:0] irq_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] id_q, id_d;

  logic [3:0] rise;
  logic [3:0] eligible;
  logic [1:0] win_id;
  logic       grant;
  logic [3:0] grant_clr;

  assign rise     = IRQ & ~irq_q;
  assign eligible = pending_q & ~mask_q;
  assign grant    = (state_q == StIdle) && ACCEPT && (eligible != 4'b0000);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  // Rotating search starting at the source after the last one granted.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win_id = ptr_q;
    found  = 1'b0;
    idx    = 2'b00;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && eligible[idx]) begin
        win_id = idx;
        found  = 1'b1;
      end
    end
  end

  // Pointer moves only on a grant.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = win_id + 2'd1;
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ptr_q <= 2'b00;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest-numbered eligible source wins.
  always_comb begin
    if      (eligible[0]) win_id = 2'd0;
    else if (eligible[1]) win_id = 2'd1;
    else if (eligible[2]) win_id = 2'd2;
    else                  win_id = 2'd3;
  end
`endif

  // Pending update; a same-cycle rising edge beats the grant clear.
  always_comb begin
    grant_clr = 4'b0000;
    if (grant) grant_clr = 4'b0001 << win_id;
    pending_d = (pending_q & ~grant_clr) | rise;
  end

  // Mask load and vector ID latch.
  always_comb begin
    mask_d = mask_q;
    if (MASK_WE) mask_d = MASK_D;
    id_d = id_q;
    if (grant) id_d = win_id;
  end

  // Sequencer next state and Moore outputs decoded from the state register.
  always_comb begin
    state_d = state_q;
    EPC_WE  = 1'b0;
    EPC_RE  = 1'b0;
    BUSY    = 1'b1;
    unique case (state_q)
      StIdle: begin
        BUSY = 1'b0;
        if (grant) state_d = StVector;
      end
      StVector: begin
        EPC_WE  = 1'b1;
        state_d = StService;
      end
      StService: begin
        if (ERET) state_d = StRestore;
      end
      StRestore: begin
        EPC_RE  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      irq_q     <= 4'b0000;
      pending_q <= 4'b0000;
      mask_q    <= 4'b0000;
      id_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      irq_q     <= IRQ;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
    end
  end

  assign MASK_Q  = mask_q;
  assign PENDING = pending_q;
  assign EPC_ID  = id_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge.
module tb_irq_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] IRQ;
  logic       ACCEPT;
  logic       ERET;
  logic       MASK_WE;
  logic [3:0] MASK_D;
  logic [3:0] MASK_Q;
  logic [3:0] PENDING;
  logic       EPC_WE;
  logic       EPC_RE;
  logic [1:0] EPC_ID;
  logic       BUSY;

  int n_total = 0;
  int n_bad   = 0;

  irq_sequencer dut (
    .CLK     (CLK),
    .RST     (RST),
    .IRQ     (IRQ),
    .ACCEPT  (ACCEPT),
    .ERET    (ERET),
    .MASK_WE (MASK_WE),
    .MASK_D  (MASK_D),
    .MASK_Q  (MASK_Q),
    .PENDING (PENDING),
    .EPC_WE  (EPC_WE),
    .EPC_RE  (EPC_RE),
    .EPC_ID  (EPC_ID),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ERET issued from SERVICE: restore strobe next cycle, idle the cycle after.
  task automatic do_eret(input string tag);
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    check_eq({tag, "_re"}, EPC_RE, 1);
    check_eq({tag, "_re_we"}, EPC_WE, 0);
    tick();
    check_eq({tag, "_idle"}, BUSY, 0);
    check_eq({tag, "_re_off"}, EPC_RE, 0);
  endtask

  logic [1:0] exp_first, exp_second;
  int         we_count;

  initial begin
    RST = 1'b1; IRQ = 4'b0; ACCEPT = 1'b0; ERET = 1'b0; MASK_WE = 1'b0; MASK_D = 4'b0;
    tick(); tick();
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_mask", MASK_Q, 0);
    check_eq("rst_pend", PENDING, 0);
    check_eq("rst_we", EPC_WE, 0);
    check_eq("rst_re", EPC_RE, 0);
    check_eq("rst_id", EPC_ID, 0);
    RST = 1'b0;
    tick();

    // Reset asserted mid-SERVICE.
    MASK_WE = 1'b1; MASK_D = 4'b1000; IRQ = 4'b0001; ACCEPT = 1'b1;
    tick();
    MASK_WE = 1'b0;
    check_eq("mr_mask", MASK_Q, 4'b1000);
    check_eq("mr_pend", PENDING, 4'b0001);
    tick();
    check_eq("mr_we", EPC_WE, 1);
    check_eq("mr_id", EPC_ID, 0);
    IRQ = 4'b0011;
    tick();
    check_eq("mr_svc_busy", BUSY, 1);
    check_eq("mr_svc_pend", PENDING, 4'b0010);
    IRQ = 4'b0000; ACCEPT = 1'b0;
    RST = 1'b1;
    #1;
    check_eq("ar_busy", BUSY, 0);
    check_eq("ar_we", EPC_WE, 0);
    check_eq("ar_re", EPC_RE, 0);
    check_eq("ar_pend", PENDING, 0);
    check_eq("ar_mask", MASK_Q, 0);
    tick();
    RST = 1'b0;
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    check_eq("ar_eret_re", EPC_RE, 0);
    check_eq("ar_eret_busy", BUSY, 0);
    tick();
    check_eq("ar_eret_re2", EPC_RE, 0);

    // Single request on source 2.
    ACCEPT = 1'b1; IRQ = 4'b0100;                      // cycle 0
    tick();                                            // cycle 1
    check_eq("s_pend", PENDING, 4'b0100);
    check_eq("s_we1", EPC_WE, 0);
    tick();                                            // cycle 2
    check_eq("s_we2", EPC_WE, 1);
    check_eq("s_id", EPC_ID, 2);
    check_eq("s_pclr", PENDING, 0);
    tick();                                            // cycle 3
    IRQ = 4'b0000;
    check_eq("s_we3", EPC_WE, 0);
    check_eq("s_busy3", BUSY, 1);
    tick(); tick();                                    // cycle 5
    do_eret("s");                                      // RE in 6, idle in 7

    // Simultaneous requests on sources 1 and 3.
`ifdef IRQ_ROUND_ROBIN_EN
    exp_first = 2'd3; exp_second = 2'd1;               // pointer is 3 after source 2
`else
    exp_first = 2'd1; exp_second = 2'd3;
`endif
    IRQ = 4'b1010;
    tick();
    check_eq("m_pend", PENDING, 4'b1010);
    tick();
    IRQ = 4'b0000;
    check_eq("m_we1", EPC_WE, 1);
    check_eq("m_id1", EPC_ID, 32'(exp_first));
    check_eq("m_pend1", PENDING, 4'b1010 & ~(4'b0001 << exp_first));
    tick();
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    check_eq("m_re", EPC_RE, 1);
    tick();
    check_eq("m_gap_we", EPC_WE, 0);
    check_eq("m_gap_busy", BUSY, 0);
    tick();
    check_eq("m_we2", EPC_WE, 1);
    check_eq("m_id2", EPC_ID, 32'(exp_second));
    check_eq("m_pend2", PENDING, 0);
    tick();
    do_eret("m2");

`ifdef IRQ_ROUND_ROBIN_EN
    // Last grant was source 1, so a fresh 1010 starts the search at source 2.
    IRQ = 4'b1010;
    tick(); tick();
    IRQ = 4'b0000;
    check_eq("rr_id1", EPC_ID, 3);
    tick();
    do_eret("rr1");
    tick();
    check_eq("rr_id2", EPC_ID, 1);
    tick();
    do_eret("rr2");
`endif

    // Masked source pends but does not fire until unmasked.
    MASK_WE = 1'b1; MASK_D = 4'b0001;
    tick();
    MASK_WE = 1'b0; IRQ = 4'b0001;
    tick();
    check_eq("k_pend", PENDING, 4'b0001);
    check_eq("k_we_a", EPC_WE, 0);
    tick();
    check_eq("k_we_b", EPC_WE, 0);
    check_eq("k_busy", BUSY, 0);
    MASK_WE = 1'b1; MASK_D = 4'b0000;
    tick();
    MASK_WE = 1'b0;
    check_eq("k_mask0", MASK_Q, 0);
    check_eq("k_we_c", EPC_WE, 0);
    tick();
    IRQ = 4'b0000;
    check_eq("k_we", EPC_WE, 1);
    check_eq("k_id", EPC_ID, 0);
    tick();
    do_eret("k");

    // No nesting, and ACCEPT low holds IDLE.
    IRQ = 4'b0100;
    tick(); tick();
    IRQ = 4'b0000;
    check_eq("n_we", EPC_WE, 1);
    tick();
    IRQ = 4'b1000;
    tick();
    IRQ = 4'b0000;
    check_eq("n_pend", PENDING, 4'b1000);
    check_eq("n_we_svc", EPC_WE, 0);
    check_eq("n_busy", BUSY, 1);
    tick();
    check_eq("n_we_svc2", EPC_WE, 0);
    ACCEPT = 1'b0;
    do_eret("n");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("n_hold_busy", BUSY, 0);
      check_eq("n_hold_we", EPC_WE, 0);
    end
    check_eq("n_hold_pend", PENDING, 4'b1000);
    ACCEPT = 1'b1;
    tick();
    check_eq("n_acc_we", EPC_WE, 1);
    check_eq("n_acc_id", EPC_ID, 3);
    tick();
    do_eret("n2");

    // Level-held request grants once.
    we_count = 0;
    IRQ = 4'b0010;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (EPC_WE) we_count++;
      ERET = (i == 4);
    end
    ERET = 1'b0;
    IRQ = 4'b0000;
    check_eq("lvl_grants", we_count, 1);
    check_eq("lvl_id", EPC_ID, 1);
    tick(); tick();
    check_eq("lvl_busy", BUSY, 0);
    check_eq("lvl_pend", PENDING, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // EPC strobes must never overlap.
  always @(negedge CLK) begin
    if (!RST && EPC_WE && EPC_RE) check_eq("we_re_excl", {EPC_WE, EPC_RE}, 2'b10);
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Four-input interrupt controller that sequences the EPC register of the single-cycle MIPS core. It latches interrupt requests, masks and prioritises them, and picks one at an instruction boundary. It then drives the EPC write strobe and vector ID, waits for the handler's ERET, and drives the EPC read (restore) strobe. It sits between the external interrupt lines and the EPC/PC-select logic in the top-level datapath.

## Interface
- No parameters; request count fixed at 4 (2-bit ID matches EPC vector select).
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IRQ  in  4  raw interrupt request lines, synchronous to CLK; bit n = source n.
- ACCEPT  in  1  core is at an instruction boundary; interrupt may be taken this cycle.
- ERET  in  1  one-cycle pulse: return-from-interrupt instruction executing.
- MASK_WE  in  1  write strobe for mask register.
- MASK_D  in  4  mask write data; 1 = source disabled.
- MASK_Q  out  4  current mask register.
- PENDING  out  4  current pending register.
- EPC_WE  out  1  to EPC WE; latch PC and load vector.
- EPC_RE  out  1  to EPC RE; restore latched PC.
- EPC_ID  out  2  to EPC ID; vector select of the granted source.
- BUSY  out  1  handler in progress (any state other than IDLE).

## Operation
- Edge capture: irq_q registers IRQ each cycle. The pending bit n is set on a 0->1 transition of IRQ[n]. Level-held lines do not retrigger.
- A pending bit is cleared in the cycle its source is granted. If a new rising edge on the same bit arrives in that same cycle, the set wins.
- Masking: eligible = PENDING & ~MASK_Q. Masked sources still set pending and fire once unmasked.
- MASK_WE loads MASK_D at the clock edge, in any state.
- FSM, 4 states, registered (Moore) outputs:
  - IDLE: all strobes 0. If ACCEPT=1 and eligible!=0, go to VECTOR, latch the winner into EPC_ID, and clear its pending bit.
  - VECTOR: EPC_WE=1 for exactly one cycle. Always go to SERVICE.
  - SERVICE: wait. ERET=1 goes to RESTORE. New requests only pend; there is no nesting.
  - RESTORE: EPC_RE=1 for exactly one cycle. Always go to IDLE.
- ERET in IDLE or VECTOR is ignored.
- EPC_WE and EPC_RE are never high in the same cycle.
- EPC_ID holds its value from grant until the next grant.
- Priority (default): fixed, source 0 highest, source 3 lowest.

## Timing
- Reset values: state IDLE, MASK_Q=4'b0000, PENDING=0, irq_q=0, EPC_WE=0, EPC_RE=0, EPC_ID=2'b00, BUSY=0. Round-robin pointer = 0.
- Request latency: IRQ rises in cycle t, pending is set at edge t+1, and the grant can occur at edge t+2 if ACCEPT=1 in cycle t+1. EPC_WE is high during cycle t+2.
- ERET in cycle s gives EPC_RE=1 during cycle s+1 and IDLE in s+2.
- Back-to-back: the earliest next grant is decided in the first IDLE cycle. This gives at least 1 idle cycle between EPC_RE and the next EPC_WE.
- RST mid-operation (any state) returns immediately to IDLE with all strobes 0. Pending requests and the mask are lost.
- ACCEPT low holds IDLE regardless of pending.

## Configuration
- IRQ_ROUND_ROBIN_EN defined: rotating priority. After granting source k, the search order starts at (k+1) mod 4, wrapping around. The pointer updates on grant only and resets to 0.
- Undefined: fixed priority, 0 highest. No pointer register.

## Test plan
- Reset: assert RST mid-SERVICE -> BUSY=0, EPC_WE=EPC_RE=0, PENDING=0, MASK_Q=0 immediately. Afterwards ERET -> no EPC_RE.
- Single request: IRQ[2] rises in cycle 0 with ACCEPT=1 -> EPC_WE=1, EPC_ID=2'b10 in cycle 2, PENDING[2]=0. ERET in cycle 5 -> EPC_RE=1 in cycle 6, BUSY=0 in cycle 7.
- Simultaneous: IRQ=4'b1010 rises together -> grant ID=1 first. After ERET/RESTORE, ID=3 is granted in a separate sequence. In the round-robin build, a prior grant of ID=1 followed by a fresh 4'b1010 -> ID=3 first.
- Masking: MASK_D=4'b0001 written, IRQ[0] rises -> PENDING=4'b0001, no EPC_WE. Write MASK_D=0 with ACCEPT=1 -> EPC_WE with ID=0 two cycles later.
- No nesting/ACCEPT: IRQ[3] rises during SERVICE -> PENDING[3]=1, no strobe until after RESTORE. With ACCEPT=0 held, it stays IDLE. Raising ACCEPT -> EPC_WE with ID=3 on the next edge.
- Level hold: IRQ[1] held high for 20 cycles -> exactly one grant.
